// File: rtl/punc_controller.sv
// Multi-cycle fetch/decode/execute control FSM for the PUnC LC3 datapath.
// Optional: define PUNC_ILLEGAL_HALT_EN to halt on RTI (1000) and reserved (1101) opcodes.
module punc_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        PC_ld_register,
  output logic        PC_ld_offset,
  output logic        PC_clr,
  output logic        PC_inc,
  output logic        IR_ld,
  output logic [2:0]  readCtrAddr,
  output logic [15:0] ctrAddr,
  output logic        immSelect,
  output logic [15:0] immValue,
  output logic [2:0]  regFile_r_addr_0,
  output logic [2:0]  regFile_r_addr_1,
  output logic [2:0]  regFile_w_addr_0,
  output logic        regFile_w_en,
  output logic [2:0]  selectALU,
  output logic        modCond,
  output logic [2:0]  W_dataSelect_RF,
  output logic [15:0] LOAD_offset,
  output logic [15:0] WRITE_offset,
  output logic        memWriteEn,
  output logic [1:0]  W_addrSelect_M,
  output logic        halted
);

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpLdr  = 4'b0110;
  localparam logic [3:0] OpStr  = 4'b0111;
  localparam logic [3:0] OpRti  = 4'b1000;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpLdi  = 4'b1010;
  localparam logic [3:0] OpSti  = 4'b1011;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpRes  = 4'b1101;
  localparam logic [3:0] OpLea  = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  typedef enum logic [2:0] {StReset, StFetch, StDecode, StExec1, StExec2, StHalt} state_e;

  state_e      state_q, state_d;
  logic        ldi_pass_q, ldi_pass_d;
  logic [3:0]  op;
  logic [15:0] sext5, sext6, sext9, sext11;
  logic        ld_reg, ld_off, inc, irld, wen, mwe, modc;

  assign op     = ir[15:12];
  assign sext5  = {{11{ir[4]}}, ir[4:0]};
  assign sext6  = {{10{ir[5]}}, ir[5:0]};
  assign sext9  = {{7{ir[8]}}, ir[8:0]};
  assign sext11 = {{5{ir[10]}}, ir[10:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StReset;
      ldi_pass_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ldi_pass_q <= ldi_pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ldi_pass_d = 1'b0;
    unique case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec1;
      StExec1: begin
        case (op)
          OpJsr, OpLd, OpLdr, OpLdi, OpSt, OpStr, OpSti: state_d = StExec2;
          OpTrap: state_d = StHalt;
`ifdef PUNC_ILLEGAL_HALT_EN
          OpRti, OpRes: state_d = StHalt;
`else
          OpRti, OpRes: state_d = StFetch;
`endif
          default: state_d = StFetch;
        endcase
      end
      StExec2: begin
        // LDI needs a second EXEC2 pass: first the pointer read, then the write-back.
        if (op == OpLdi && !ldi_pass_q) begin
          state_d    = StExec2;
          ldi_pass_d = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    ld_reg           = 1'b0;
    ld_off           = 1'b0;
    inc              = 1'b0;
    irld             = 1'b0;
    wen              = 1'b0;
    mwe              = 1'b0;
    modc             = 1'b0;
    PC_clr           = 1'b0;
    readCtrAddr      = 3'd0;
    immSelect        = 1'b0;
    immValue         = (state_q == StReset) ? 16'h0000 : sext5;
    regFile_r_addr_0 = 3'd0;
    regFile_r_addr_1 = 3'd0;
    regFile_w_addr_0 = 3'd0;
    selectALU        = 3'd0;
    W_dataSelect_RF  = 3'd0;
    LOAD_offset      = 16'h0000;
    WRITE_offset     = 16'h0000;
    W_addrSelect_M   = 2'd0;
    halted           = 1'b0;
    unique case (state_q)
      StReset:  PC_clr = 1'b1;
      StFetch:  readCtrAddr = 3'd0;
      StDecode: begin
        irld = 1'b1;
        inc  = 1'b1;
      end
      StExec1: begin
        case (op)
          OpAdd, OpAnd, OpNot: begin
            regFile_r_addr_0 = ir[8:6];
            regFile_r_addr_1 = ir[2:0];
            immSelect        = (op != OpNot) & ir[5];
            selectALU        = (op == OpAdd) ? 3'd0 : (op == OpAnd) ? 3'd1 : 3'd2;
            regFile_w_addr_0 = ir[11:9];
            wen              = 1'b1;
            modc             = 1'b1;
          end
          OpBr: begin
            WRITE_offset = sext9;
            ld_off       = (ir[11] & N) | (ir[10] & Z) | (ir[9] & P);
          end
          OpJmp: begin
            regFile_r_addr_0 = ir[8:6];
            ld_reg           = 1'b1;
          end
          OpJsr: begin
            regFile_w_addr_0 = 3'd7;
            wen              = 1'b1;
            W_dataSelect_RF  = 3'd2;
          end
          OpLd, OpLdi: begin
            readCtrAddr      = 3'd2;
            LOAD_offset      = sext9;
            regFile_r_addr_0 = ir[8:6];
          end
          OpLdr: begin
            readCtrAddr      = 3'd4;
            LOAD_offset      = sext6;
            regFile_r_addr_0 = ir[8:6];
          end
          OpLea: begin
            regFile_w_addr_0 = ir[11:9];
            wen              = 1'b1;
            W_dataSelect_RF  = 3'd3;
            LOAD_offset      = sext9;
          end
          OpSt: begin
            regFile_r_addr_0 = ir[11:9];
            selectALU        = 3'd4;
            W_addrSelect_M   = 2'd0;
            WRITE_offset     = sext9;
          end
          OpStr: begin
            // Base register drives rf0 while the write address is captured.
            regFile_r_addr_0 = ir[8:6];
            selectALU        = 3'd4;
            W_addrSelect_M   = 2'd1;
            WRITE_offset     = sext6;
          end
          OpSti: begin
            regFile_r_addr_0 = ir[11:9];
            selectALU        = 3'd4;
            readCtrAddr      = 3'd2;
            LOAD_offset      = sext9;
          end
          default: ;
        endcase
      end
      StExec2: begin
        case (op)
          OpJsr: begin
            if (ir[11]) begin
              ld_off       = 1'b1;
              WRITE_offset = sext11;
            end else begin
              ld_reg           = 1'b1;
              regFile_r_addr_0 = ir[8:6];
            end
          end
          OpLd, OpLdr: begin
            regFile_w_addr_0 = ir[11:9];
            wen              = 1'b1;
            W_dataSelect_RF  = 3'd1;
          end
          OpLdi: begin
            if (!ldi_pass_q) begin
              readCtrAddr = 3'd3;
            end else begin
              regFile_w_addr_0 = ir[11:9];
              wen              = 1'b1;
              W_dataSelect_RF  = 3'd1;
            end
          end
          OpSt, OpStr, OpSti: begin
            regFile_r_addr_0 = ir[11:9];
            selectALU        = 3'd4;
            mwe              = 1'b1;
            W_addrSelect_M   = (op == OpSti) ? 2'd2 : 2'd3;
          end
          default: ;
        endcase
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  // Commit strobes are masked while reset is held so an aborted instruction leaves no trace.
  assign PC_ld_register = ld_reg & rst;
  assign PC_ld_offset   = ld_off & rst;
  assign PC_inc         = inc & rst;
  assign IR_ld          = irld & rst;
  assign regFile_w_en   = wen & rst;
  assign memWriteEn     = mwe & rst;
  assign modCond        = modc & rst;
  assign ctrAddr        = 16'h0000;

endmodule

// File: tb/tb_punc_controller.sv
// Self-checking bench for punc_controller: per-instruction expected output sequences
// are built from the opcode rules and compared with the DUT outputs every cycle.
module tb_punc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir  = 16'h0000;
  logic        N = 1'b0, Z = 1'b0, P = 1'b0;
  logic        PC_ld_register, PC_ld_offset, PC_clr, PC_inc, IR_ld;
  logic [2:0]  readCtrAddr;
  logic [15:0] ctrAddr;
  logic        immSelect;
  logic [15:0] immValue;
  logic [2:0]  regFile_r_addr_0, regFile_r_addr_1, regFile_w_addr_0;
  logic        regFile_w_en;
  logic [2:0]  selectALU;
  logic        modCond;
  logic [2:0]  W_dataSelect_RF;
  logic [15:0] LOAD_offset, WRITE_offset;
  logic        memWriteEn;
  logic [1:0]  W_addrSelect_M;
  logic        halted;

  punc_controller dut (
    .clk(clk), .rst(rst), .ir(ir), .N(N), .Z(Z), .P(P),
    .PC_ld_register(PC_ld_register), .PC_ld_offset(PC_ld_offset), .PC_clr(PC_clr),
    .PC_inc(PC_inc), .IR_ld(IR_ld), .readCtrAddr(readCtrAddr), .ctrAddr(ctrAddr),
    .immSelect(immSelect), .immValue(immValue), .regFile_r_addr_0(regFile_r_addr_0),
    .regFile_r_addr_1(regFile_r_addr_1), .regFile_w_addr_0(regFile_w_addr_0),
    .regFile_w_en(regFile_w_en), .selectALU(selectALU), .modCond(modCond),
    .W_dataSelect_RF(W_dataSelect_RF), .LOAD_offset(LOAD_offset),
    .WRITE_offset(WRITE_offset), .memWriteEn(memWriteEn), .W_addrSelect_M(W_addrSelect_M),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_ld_reg, pc_ld_off, pc_clr, pc_inc, ir_ld;
    logic [2:0]  rd_sel;
    logic [15:0] ctr_addr;
    logic        imm_sel;
    logic [15:0] imm_val;
    logic [2:0]  ra0, ra1, wa;
    logic        wen;
    logic [2:0]  alu;
    logic        mod_cond;
    logic [2:0]  wds;
    logic [15:0] load_off, write_off;
    logic        mem_we;
    logic [1:0]  was;
    logic        halted;
  } outs_t;

  int    n_checks = 0;
  int    n_fails  = 0;
  outs_t exp_q[$];
  bit    exp_halt;
  outs_t got;
  outs_t want;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v;
    for (int i = bits; i < 16; i++) r[i] = v[bits-1];
    return r;
  endfunction

  function automatic outs_t dut_out();
    outs_t o;
    o.pc_ld_reg = PC_ld_register; o.pc_ld_off = PC_ld_offset; o.pc_clr = PC_clr;
    o.pc_inc = PC_inc; o.ir_ld = IR_ld; o.rd_sel = readCtrAddr; o.ctr_addr = ctrAddr;
    o.imm_sel = immSelect; o.imm_val = immValue; o.ra0 = regFile_r_addr_0;
    o.ra1 = regFile_r_addr_1; o.wa = regFile_w_addr_0; o.wen = regFile_w_en;
    o.alu = selectALU; o.mod_cond = modCond; o.wds = W_dataSelect_RF;
    o.load_off = LOAD_offset; o.write_off = WRITE_offset; o.mem_we = memWriteEn;
    o.was = W_addrSelect_M; o.halted = halted;
    return o;
  endfunction

  // Expected per-cycle outputs of one instruction, FETCH through its last execute cycle.
  task automatic build_seq(input logic [15:0] x, input logic n, input logic z, input logic p);
    outs_t b, d, e1, e2, e3;
    logic [3:0] op;
    int n_ex;
    op = x[15:12];
    exp_q.delete();
    exp_halt = 1'b0;
    b = '0;
    b.imm_val = sx(x, 5);
    d = b; d.ir_ld = 1'b1; d.pc_inc = 1'b1;
    e1 = b; e2 = b; e3 = b; n_ex = 1;
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        e1.ra0 = x[8:6]; e1.ra1 = x[2:0]; e1.wa = x[11:9]; e1.wen = 1'b1; e1.mod_cond = 1'b1;
        e1.imm_sel = (op == 4'b1001) ? 1'b0 : x[5];
        e1.alu = (op == 4'b0001) ? 3'd0 : (op == 4'b0101) ? 3'd1 : 3'd2;
      end
      4'b0000: begin
        e1.write_off = sx(x, 9);
        e1.pc_ld_off = (x[11] && n) || (x[10] && z) || (x[9] && p);
      end
      4'b1100: begin e1.ra0 = x[8:6]; e1.pc_ld_reg = 1'b1; end
      4'b0100: begin
        e1.wa = 3'd7; e1.wen = 1'b1; e1.wds = 3'd2; n_ex = 2;
        if (x[11]) begin e2.pc_ld_off = 1'b1; e2.write_off = sx(x, 11); end
        else begin e2.pc_ld_reg = 1'b1; e2.ra0 = x[8:6]; end
      end
      4'b0010, 4'b0110, 4'b1010: begin
        e1.rd_sel = (op == 4'b0110) ? 3'd4 : 3'd2;
        e1.load_off = (op == 4'b0110) ? sx(x, 6) : sx(x, 9);
        e1.ra0 = x[8:6];
        if (op == 4'b1010) begin
          e2.rd_sel = 3'd3; n_ex = 3;
          e3.wa = x[11:9]; e3.wen = 1'b1; e3.wds = 3'd1;
        end else begin
          e2.wa = x[11:9]; e2.wen = 1'b1; e2.wds = 3'd1; n_ex = 2;
        end
      end
      4'b1110: begin e1.wa = x[11:9]; e1.wen = 1'b1; e1.wds = 3'd3; e1.load_off = sx(x, 9); end
      4'b0011, 4'b0111, 4'b1011: begin
        e1.alu = 3'd4; n_ex = 2;
        if (op == 4'b0011) begin e1.ra0 = x[11:9]; e1.write_off = sx(x, 9); end
        if (op == 4'b0111) begin e1.ra0 = x[8:6]; e1.was = 2'd1; e1.write_off = sx(x, 6); end
        if (op == 4'b1011) begin e1.ra0 = x[11:9]; e1.rd_sel = 3'd2; e1.load_off = sx(x, 9); end
        e2.ra0 = x[11:9]; e2.alu = 3'd4; e2.mem_we = 1'b1;
        e2.was = (op == 4'b1011) ? 2'd2 : 2'd3;
      end
      4'b1111: exp_halt = 1'b1;
`ifdef PUNC_ILLEGAL_HALT_EN
      4'b1000, 4'b1101: exp_halt = 1'b1;
`endif
      default: ;
    endcase
    exp_q.push_back(b);
    exp_q.push_back(d);
    exp_q.push_back(e1);
    if (n_ex >= 2) exp_q.push_back(e2);
    if (n_ex >= 3) exp_q.push_back(e3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  function automatic logic [15:0] rand_ir(input logic [3:0] op);
    logic [15:0] v;
    v = 16'($urandom);
    v[15:12] = op;
    return v;
  endfunction

  task automatic test_reset();
    want = '0;
    want.pc_clr = 1'b1;
    rst = 1'b0;
    ir  = 16'h1261;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      got = dut_out();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL reset_state k=%0d: got %h expected %h", k, got, want);
      end
      rst = 1'b1;
      #1;
    end
    tick();
    ir = 16'h0000; {N, Z, P} = 3'b111;
    build_seq(ir, N, Z, P);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      got = dut_out();
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fails++;
        $display("FAIL reset_first_instr step %0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_alu();
    logic [3:0] ops [3];
    ops[0] = 4'b0001; ops[1] = 4'b0101; ops[2] = 4'b1001;
    for (int t = 0; t < 25; t++) begin
      ir = (t == 0) ? 16'h1261 : rand_ir(ops[$urandom_range(0, 2)]);
      {N, Z, P} = 3'($urandom);
      build_seq(ir, N, Z, P);
      #1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        got = dut_out();
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fails++;
          $display("FAIL alu ir=%h step %0d: got %h expected %h", ir, i, got, exp_q[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 20; t++) begin
      if (t < 2) begin
        ir = 16'h0402; {N, Z, P} = (t == 0) ? 3'b010 : 3'b101;
      end else begin
        ir = rand_ir(4'b0000); {N, Z, P} = 3'($urandom);
      end
      build_seq(ir, N, Z, P);
      #1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        got = dut_out();
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fails++;
          $display("FAIL branch ir=%h nzp=%b step %0d: got %h expected %h",
                   ir, {N, Z, P}, i, got, exp_q[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_ldi();
    ir = 16'hA5FF; {N, Z, P} = 3'b001;
    build_seq(ir, N, Z, P);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      got = dut_out();
      n_checks++;
      if (got !== exp_q[i]) begin
        n_fails++;
        $display("FAIL ldi step %0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    tick();
    // Sixth cycle must be the next FETCH.
    n_checks++;
    if (IR_ld !== 1'b0 || readCtrAddr !== 3'd0 || regFile_w_en !== 1'b0) begin
      n_fails++;
      $display("FAIL ldi_latency: IR_ld=%b readCtrAddr=%0d w_en=%b, required 0 0 0",
               IR_ld, readCtrAddr, regFile_w_en);
    end
  endtask

  task automatic test_jsr();
    for (int t = 0; t < 10; t++) begin
      ir = (t == 0) ? 16'h4801 : rand_ir(4'b0100);
      build_seq(ir, N, Z, P);
      #1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        got = dut_out();
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fails++;
          $display("FAIL jsr ir=%h step %0d: got %h expected %h", ir, i, got, exp_q[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [15:0] hv [3];
    hv[0] = 16'hF025; hv[1] = 16'hD000; hv[2] = 16'h8000;
    for (int t = 0; t < 3; t++) begin
      ir = hv[t];
      build_seq(ir, N, Z, P);
      #1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        got = dut_out();
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fails++;
          $display("FAIL halt_seq ir=%h step %0d: got %h expected %h", ir, i, got, exp_q[i]);
        end
      end
      tick();
      for (int k = 0; k < 5; k++) begin
        if (exp_halt) ir = 16'($urandom);
        want = '0;
        want.imm_val = sx(ir, 5);
        want.halted  = exp_halt;
        #1;
        got = dut_out();
        n_checks++;
        if (got !== want) begin
          n_fails++;
          $display("FAIL halt_hold ir=%h k=%0d: got %h expected %h", ir, k, got, want);
        end
        if (!exp_halt) break;
        tick();
      end
      if (exp_halt) apply_reset();
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 300; t++) begin
      ir = 16'($urandom);
      {N, Z, P} = 3'($urandom);
      build_seq(ir, N, Z, P);
      #1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        got = dut_out();
        n_checks++;
        if (got !== exp_q[i]) begin
          n_fails++;
          $display("FAIL b2b ir=%h step %0d: got %h expected %h", ir, i, got, exp_q[i]);
        end
      end
      tick();
      if (exp_halt) begin
        n_checks++;
        if (halted !== 1'b1) begin
          n_fails++;
          $display("FAIL b2b_halt ir=%h: halted=%b required 1", ir, halted);
        end
        apply_reset();
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] ops [7];
    int k;
    ops[0] = 4'b0001; ops[1] = 4'b0100; ops[2] = 4'b1010; ops[3] = 4'b0011;
    ops[4] = 4'b0111; ops[5] = 4'b0110; ops[6] = 4'b1110;
    for (int t = 0; t < 30; t++) begin
      ir = rand_ir(ops[$urandom_range(0, 6)]);
      build_seq(ir, N, Z, P);
      k = $urandom_range(1, exp_q.size() - 1);
      #1;
      for (int i = 0; i <= k; i++) begin
        if (i > 0) tick();
        want = exp_q[i];
        if (i == k) begin
          rst = 1'b0;
          want.pc_ld_reg = 1'b0; want.pc_ld_off = 1'b0; want.pc_inc = 1'b0;
          want.ir_ld = 1'b0; want.wen = 1'b0; want.mem_we = 1'b0; want.mod_cond = 1'b0;
          #1;
        end
        got = dut_out();
        n_checks++;
        if (got !== want) begin
          n_fails++;
          $display("FAIL abort ir=%h k=%0d step %0d: got %h expected %h", ir, k, i, got, want);
        end
      end
      tick();
      want = '0;
      want.pc_clr = 1'b1;
      got = dut_out();
      n_checks++;
      if (got !== want) begin
        n_fails++;
        $display("FAIL abort_to_reset ir=%h: got %h expected %h", ir, got, want);
      end
      rst = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_ldi();
    test_jsr();
    test_halt();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
